phase_a_seq: RTL and testbench

- Parametrised, multi-cycle successor to the single-shot phase-A reduction stage.
- Computes new_a = a mod m for an AW-bit operand and a W-bit modulus.
- Uses radix-2^STEP restoring reduction. Each trial subtraction is performed as an addition of the W+2-bit negated modulus m_n.
- Sits between operand load and the Montgomery multiply pipeline, using the same en/en_out pulse handshake as the existing stages.

---
 rtl/phase_a_seq.sv | 163 ++++++++++++++++
 tb/tb_phase_a_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_a_seq.sv
// Multi-cycle a mod m reduction: radix-2^STEP restoring division, one digit per clock, MSB first.
// Optional build macro PHASE_A_SEQ_INTERNAL_NEG_EN derives m_n from m internally and ignores the m_n port.
module phase_a_seq #(
  parameter int W    = 3072,
  parameter int AW   = 6144,
  parameter int STEP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a,
  input  logic [W-1:0]  m,
  input  logic [W+1:0]  m_n,
  input  logic          en,
  output logic [W-1:0]  new_a,
  output logic          en_out,
  output logic          busy,
  output logic          err
);

  localparam int N  = AW / STEP;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [AW-1:0]   r_a;
  logic [W+1:0]    r_m_n;
  logic [W-1:0]    r_r;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_new_a;
  logic            r_en_out;
  logic            r_err;

  logic            w_accept;
  logic            w_busy;
  logic            w_done;
  logic            w_last;
  logic            w_m_zero;
  logic [W+1:0]    w_m_n_src;
  logic [STEP-1:0] w_digit;

  // Remainder chain: w_r[0] is the digit-boundary remainder, w_r[STEP] the next one.
  logic [W-1:0]    w_r [STEP+1];
  logic [W+1:0]    w_t [STEP];
  logic [W+1:0]    w_s [STEP];
  logic [STEP-1:0] w_unused_s_hi;

  assign w_m_zero = (m == '0);
  assign w_last   = (r_cnt == CW'(1));
  assign w_digit  = r_a[AW-1 -: STEP];

`ifdef PHASE_A_SEQ_INTERNAL_NEG_EN
  logic w_unused_m_n;
  assign w_unused_m_n = ^m_n;
  assign w_m_n_src    = (~{2'b00, m}) + {{(W+1){1'b0}}, 1'b1};
`else
  assign w_m_n_src    = m_n;
`endif

  assign w_r[0] = r_r;

  // Trial subtraction by adding 2^(W+2)-m; a set top bit means the trial went negative.
  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_stage
      assign w_t[gi] = {1'b0, w_r[gi], w_digit[STEP-1-gi]};
      assign w_s[gi] = w_t[gi] + r_m_n;
      assign w_r[gi+1] = w_s[gi][W+1] ? w_t[gi][W-1:0] : w_s[gi][W-1:0];
      assign w_unused_s_hi[gi] = w_s[gi][W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_next = w_m_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (en) begin
          w_state_next = w_m_zero ? S_DONE : S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: w_accept = en;
      S_RUN:  w_busy   = 1'b1;
      S_DONE: begin
        w_done   = 1'b1;
        w_accept = en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_m_n    <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_new_a  <= '0;
      r_en_out <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // The pulse trails DONE by one edge so it survives a same-edge re-accept.
      r_en_out <= w_done;
      if (w_accept) begin
        r_a   <= a;
        r_m_n <= w_m_n_src;
        r_r   <= '0;
        r_cnt <= CW'(N);
        r_err <= w_m_zero;
        if (w_m_zero) begin
          r_new_a <= '0;
        end
      end else if (r_state == S_RUN) begin
        r_a   <= r_a << STEP;
        r_r   <= w_r[STEP];
        r_cnt <= r_cnt - 1'b1;
        if (w_last) begin
          r_new_a <= w_r[STEP];
        end
      end
    end
  end

  assign new_a  = r_new_a;
  assign en_out = r_en_out;
  assign busy   = w_busy;
  assign err    = r_err;

endmodule

// File: tb/tb_phase_a_seq.sv
// Bench for phase_a_seq: small instance checked every cycle against an edge-count model,
// large instance checked per job against a wide modulo.
`timescale 1ns/1ps
module tb_phase_a_seq;

  localparam int W = 8, AW = 16, STEP = 2, N = AW / STEP;
  localparam int BW = 3072, BAW = 6144, BSTEP = 4, BN = BAW / BSTEP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0]  s_a = '0;
  logic [W-1:0]   s_m = '0;
  logic [W+1:0]   s_m_n = '0;
  logic           s_en = 1'b0;
  logic [W-1:0]   s_new_a;
  logic           s_en_out, s_busy, s_err;

  logic [BAW-1:0] b_a = '0;
  logic [BW-1:0]  b_m = '0;
  logic [BW+1:0]  b_m_n = '0;
  logic           b_en = 1'b0;
  logic [BW-1:0]  b_new_a;
  logic           b_en_out, b_busy, b_err;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  phase_a_seq #(.W(W), .AW(AW), .STEP(STEP)) dut_s (
    .clk(clk), .rst(rst), .a(s_a), .m(s_m), .m_n(s_m_n), .en(s_en),
    .new_a(s_new_a), .en_out(s_en_out), .busy(s_busy), .err(s_err)
  );

  phase_a_seq #(.W(BW), .AW(BAW), .STEP(BSTEP)) dut_b (
    .clk(clk), .rst(rst), .a(b_a), .m(b_m), .m_n(b_m_n), .en(b_en),
    .new_a(b_new_a), .en_out(b_en_out), .busy(b_busy), .err(b_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_big(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got low64 %h expected low64 %h", nm, act[63:0], exp[63:0]);
    end
  endtask

  // Job-level model: a job accepted at edge E completes at E+N (E for m==0), pulses one edge later.
  int           edge_cnt = 0;
  bit           job_valid = 1'b0;
  bit           job_m0 = 1'b0;
  int           done_edge = 0;
  int           pulse_edge = -100;
  int           prev_pulse_edge = -100;
  logic [W-1:0] job_res = '0;
  logic [W-1:0] committed = '0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (rst) begin
      job_valid       <= 1'b0;
      job_m0          <= 1'b0;
      committed       <= '0;
      pulse_edge      <= -100;
      prev_pulse_edge <= -100;
    end else if (s_en && (!job_valid || (edge_cnt + 1 > done_edge))) begin
      prev_pulse_edge <= pulse_edge;
      if (job_valid) committed <= job_res;
      job_valid  <= 1'b1;
      job_m0     <= (s_m == '0);
      job_res    <= (s_m == '0) ? '0 : W'(s_a % AW'(s_m));
      done_edge  <= edge_cnt + 1 + ((s_m == '0) ? 0 : N);
      pulse_edge <= edge_cnt + 2 + ((s_m == '0) ? 0 : N);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_busy", 32'(s_busy), 32'(job_valid && (edge_cnt < done_edge)));
      chk("cyc_en_out", 32'(s_en_out), 32'((edge_cnt == pulse_edge) || (edge_cnt == prev_pulse_edge)));
      chk("cyc_new_a", 32'(s_new_a), 32'((job_valid && (edge_cnt >= done_edge)) ? job_res : committed));
      chk("cyc_err", 32'(s_err), 32'(job_valid && job_m0));
    end
  end

  task automatic drive_small(input logic [15:0] aa, input logic [7:0] mm);
    s_a = aa;
    s_m = mm;
`ifdef PHASE_A_SEQ_INTERNAL_NEG_EN
    s_m_n = '0;
`else
    s_m_n = 10'h0 - {2'b00, mm};
`endif
  endtask

  task automatic start_small(input logic [15:0] aa, input logic [7:0] mm);
    @(negedge clk);
    drive_small(aa, mm);
    s_en = 1'b1;
    @(negedge clk);
    s_en = 1'b0;
  endtask

  // k counts negedges after the current one until en_out; bc counts busy cycles including the current one.
  task automatic wait_pulse(input string nm, input bit big, input int lim, output int k, output int bc);
    k  = -1;
    bc = big ? 0 : int'(s_busy);
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (!big && s_busy) bc++;
      if (big ? b_en_out : s_en_out) begin
        k = i;
        break;
      end
    end
    if (k < 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_small(input string nm, input logic [15:0] aa, input logic [7:0] mm,
                           input logic [7:0] exp_res, input bit exp_err, input int exp_lat);
    int k, bc;
    start_small(aa, mm);
    wait_pulse(nm, 1'b0, 40, k, bc);
    chk({nm, "_lat"}, k, exp_lat);
    chk({nm, "_new_a"}, 32'(s_new_a), 32'(exp_res));
    chk({nm, "_err"}, 32'(s_err), 32'(exp_err));
    chk({nm, "_busy_cycles"}, bc, exp_err ? 0 : N);
  endtask

  task automatic run_big(input string nm, input int mbits);
    logic [BW-1:0] aa, mm, exp;
    int k, bc;
    for (int i = 0; i < BW / 32; i++) begin
      aa[i*32 +: 32] = $urandom;
      mm[i*32 +: 32] = $urandom;
    end
    for (int i = mbits; i < BW; i++) mm[i] = 1'b0;
    mm[mbits-1] = 1'b1;
    exp = aa % mm;
    @(negedge clk);
    b_a = {{(BAW-BW){1'b0}}, aa};
    b_m = mm;
`ifdef PHASE_A_SEQ_INTERNAL_NEG_EN
    b_m_n = '0;
`else
    b_m_n = -{2'b00, mm};
`endif
    b_en = 1'b1;
    @(negedge clk);
    b_en = 1'b0;
    wait_pulse(nm, 1'b1, BN + 50, k, bc);
    chk({nm, "_lat"}, k, BN + 1);
    chk_big({nm, "_new_a"}, b_new_a, exp);
    chk({nm, "_err"}, 32'(b_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, bc, pulses, i_done;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_new_a", 32'(s_new_a), 32'h0);
    chk("rst_en_out", 32'(s_en_out), 32'h0);
    chk("rst_busy", 32'(s_busy), 32'h0);
    chk("rst_err", 32'(s_err), 32'h0);

    run_small("t1234", 16'h1234, 8'hD5, 8'hBB, 1'b0, N + 1);
    run_small("tffff", 16'hFFFF, 8'hFF, 8'h00, 1'b0, N + 1);
    run_small("t0005", 16'h0005, 8'h07, 8'h05, 1'b0, N + 1);
    run_small("m_zero", 16'h1234, 8'h00, 8'h00, 1'b1, 1);
    run_small("after_m0", 16'h1234, 8'hD5, 8'hBB, 1'b0, N + 1);

    // en during RUN must be ignored
    start_small(16'h1234, 8'hD5);
    repeat (2) @(negedge clk);
    drive_small(16'hABCD, 8'h55);
    s_en = 1'b1;
    @(negedge clk);
    s_en = 1'b0;
    wait_pulse("ignore", 1'b0, 40, k, bc);
    chk("ignore_lat", k, N + 1 - 3);
    chk("ignore_new_a", 32'(s_new_a), 32'hBB);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_en_out) pulses++;
    end
    chk("ignore_extra_pulses", pulses, 0);

    // re-accept during the DONE cycle
    start_small(16'h1234, 8'hD5);
    i_done = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!s_busy) begin
        i_done = i;
        break;
      end
    end
    chk("done_cycle_pos", i_done, N);
    drive_small(16'h0005, 8'h07);
    s_en = 1'b1;
    @(negedge clk);
    s_en = 1'b0;
    chk("reacc_old_pulse", 32'(s_en_out), 32'h1);
    chk("reacc_old_new_a", 32'(s_new_a), 32'hBB);
    chk("reacc_busy", 32'(s_busy), 32'h1);
    wait_pulse("reacc", 1'b0, 40, k, bc);
    chk("reacc_lat", k, N + 1);
    chk("reacc_new_a", 32'(s_new_a), 32'h05);

    // reset in the middle of RUN aborts without a pulse
    start_small(16'hFFFF, 8'hD5);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(s_busy), 32'h0);
    chk("abort_en_out", 32'(s_en_out), 32'h0);
    chk("abort_new_a", 32'(s_new_a), 32'h0);
    chk("abort_err", 32'(s_err), 32'h0);
    rst = 1'b0;
    drive_small(16'h1234, 8'hD5);
    s_en = 1'b1;
    @(negedge clk);
    s_en = 1'b0;
    wait_pulse("post_rst", 1'b0, 40, k, bc);
    chk("post_rst_lat", k, N + 1);
    chk("post_rst_new_a", 32'(s_new_a), 32'hBB);

    run_big("big_full", BW);
    run_big("big_mid", 1500);
    run_big("big_small", 37);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
